imm_decode_stage: RTL and testbench

//  Registered, parametrised immediate-generation stage between fetch and execute. Accepts one raw instruction per

---
 rtl/imm_pkg.sv | 60 ++++++
 rtl/imm_decode_comb.sv | 160 ++++++++++++++++
 rtl/imm_decode_stage.sv | 104 ++++++++++
 tb/tb_imm_decode_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-generation stage.
// Contents:
//   imm_fmt_e    - immediate format tag carried with every decoded entry
//   OPCODE_*     - 32-bit major opcodes that carry an immediate
//   RVC_Q*/C*_   - compressed quadrant and funct3 selectors
//   imm_entry_t  - width-independent side information stored per buffer entry
package imm_pkg;

   typedef enum logic [3:0] {
      FMT_NONE,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_SHAMT,
      FMT_CI,
      FMT_CIW,
      FMT_CL,
      FMT_CS,
      FMT_CSS,
      FMT_CB,
      FMT_CJ
   } imm_fmt_e;

   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_PIM    = 7'b0001011;  // custom-0 slot
   localparam logic [6:0] OPCODE_I      = 7'b0010011;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

   localparam logic [1:0] RVC_Q0 = 2'b00;
   localparam logic [1:0] RVC_Q1 = 2'b01;
   localparam logic [1:0] RVC_Q2 = 2'b10;

   localparam logic [2:0] C0_ADDI4SPN = 3'b000;
   localparam logic [2:0] C0_LW       = 3'b010;
   localparam logic [2:0] C0_SW       = 3'b110;
   localparam logic [2:0] C1_ADDI     = 3'b000;
   localparam logic [2:0] C1_JAL      = 3'b001;
   localparam logic [2:0] C1_LI       = 3'b010;
   localparam logic [2:0] C1_LUI      = 3'b011;  // also c.addi16sp when rd=x2
   localparam logic [2:0] C1_MISC     = 3'b100;
   localparam logic [2:0] C1_J        = 3'b101;
   localparam logic [2:0] C1_BEQZ     = 3'b110;
   localparam logic [2:0] C1_BNEZ     = 3'b111;
   localparam logic [2:0] C2_LWSP     = 3'b010;
   localparam logic [2:0] C2_SWSP     = 3'b110;

   typedef struct packed {
      imm_fmt_e fmt;
      logic     compressed;
      logic     illegal;
   } imm_entry_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Purely combinational immediate decoder.
// Ports:
//   instr_i       in   32    raw instruction (RVC in [15:0])
//   imm_o         out  XLEN  extended immediate, 0 when illegal
//   fmt_o         out  4     imm_fmt_e tag, FMT_NONE when illegal
//   compressed_o  out  1     instruction is a 16-bit encoding
//   illegal_o     out  1     no immediate format for this encoding
module imm_decode_comb
   import imm_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned C_EXT  = 1,
   parameter int unsigned PIM_EN = 1
) (
   input  logic [31:0]     instr_i,
   output logic [XLEN-1:0] imm_o,
   output logic [3:0]      fmt_o,
   output logic            compressed_o,
   output logic            illegal_o
);

   // Every immediate is first built as a 32-bit two's-complement value; zero-extended
   // formats never set bit 31, so a single sign extension to XLEN covers all of them.
   logic [31:0] w_imm32;
   imm_fmt_e    w_fmt;
   logic        w_comp;

   always_comb begin
      w_imm32 = '0;
      w_fmt   = FMT_NONE;
      w_comp  = 1'b0;
      if ((C_EXT != 0) && (instr_i[1:0] != 2'b11)) begin
         w_comp = 1'b1;
         case (instr_i[1:0])
            RVC_Q0: begin
               case (instr_i[15:13])
                  C0_ADDI4SPN: begin
                     w_fmt   = FMT_CIW;
                     w_imm32 = {22'b0, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6],
                                2'b00};
                  end
                  C0_LW: begin
                     w_fmt   = FMT_CL;
                     w_imm32 = {25'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00};
                  end
                  C0_SW: begin
                     w_fmt   = FMT_CS;
                     w_imm32 = {25'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00};
                  end
                  default: ;
               endcase
            end
            RVC_Q1: begin
               case (instr_i[15:13])
                  C1_ADDI, C1_LI: begin
                     w_fmt   = FMT_CI;
                     w_imm32 = {{26{instr_i[12]}}, instr_i[12], instr_i[6:2]};
                  end
                  C1_JAL, C1_J: begin
                     w_fmt   = FMT_CJ;
                     w_imm32 = {{20{instr_i[12]}}, instr_i[12], instr_i[8], instr_i[10:9],
                                instr_i[6], instr_i[7], instr_i[2], instr_i[11], instr_i[5:3],
                                1'b0};
                  end
                  C1_LUI: begin
                     w_fmt = FMT_CI;
                     if (instr_i[11:7] == 5'd2) begin
                        // c.addi16sp: stack adjustment in units of 16
                        w_imm32 = {{22{instr_i[12]}}, instr_i[12], instr_i[4:3], instr_i[5],
                                   instr_i[2], instr_i[6], 4'b0000};
                     end else begin
                        w_imm32 = {{14{instr_i[12]}}, instr_i[12], instr_i[6:2], 12'b0};
                     end
                  end
                  C1_MISC: begin
                     case (instr_i[11:10])
                        2'b00, 2'b01: begin  // c.srli / c.srai: shift amounts are unsigned
                           w_fmt   = FMT_CB;
                           w_imm32 = {26'b0, instr_i[12], instr_i[6:2]};
                        end
                        2'b10: begin         // c.andi
                           w_fmt   = FMT_CB;
                           w_imm32 = {{26{instr_i[12]}}, instr_i[12], instr_i[6:2]};
                        end
                        default: ;           // register-register ops carry no immediate
                     endcase
                  end
                  C1_BEQZ, C1_BNEZ: begin
                     w_fmt   = FMT_CB;
                     w_imm32 = {{23{instr_i[12]}}, instr_i[12], instr_i[6:5], instr_i[2],
                                instr_i[11:10], instr_i[4:3], 1'b0};
                  end
                  default: ;
               endcase
            end
            RVC_Q2: begin
               case (instr_i[15:13])
                  C2_LWSP: begin
                     w_fmt   = FMT_CI;
                     w_imm32 = {24'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00};
                  end
                  C2_SWSP: begin
                     w_fmt   = FMT_CSS;
                     w_imm32 = {24'b0, instr_i[8:7], instr_i[12:9], 2'b00};
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end else begin
         case (instr_i[6:0])
            OPCODE_I: begin
               if ((instr_i[14:12] == 3'b001) || (instr_i[14:12] == 3'b101)) begin
                  w_fmt   = FMT_SHAMT;
                  w_imm32 = (XLEN == 64) ? {26'b0, instr_i[25:20]} : {27'b0, instr_i[24:20]};
               end else begin
                  w_fmt   = FMT_I;
                  w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
               end
            end
            OPCODE_LOAD, OPCODE_JALR: begin
               w_fmt   = FMT_I;
               w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPCODE_STORE: begin
               w_fmt   = FMT_S;
               w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPCODE_PIM: begin
               if (PIM_EN != 0) begin
                  w_fmt   = FMT_S;
                  w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
               end
            end
            OPCODE_BRANCH: begin
               w_fmt   = FMT_B;
               w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                          instr_i[11:8], 1'b0};
            end
            OPCODE_JAL: begin
               w_fmt   = FMT_J;
               w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                          instr_i[30:21], 1'b0};
            end
            OPCODE_LUI, OPCODE_AUIPC: begin
               w_fmt   = FMT_U;
               w_imm32 = {instr_i[31:12], 12'b0};
            end
            default: ;
         endcase
      end
   end

   assign imm_o        = XLEN'($signed(w_imm32));
   assign fmt_o        = w_fmt;
   assign compressed_o = w_comp;
   assign illegal_o    = (w_fmt == FMT_NONE);

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-generation stage: decoder followed by a 2-entry in-order buffer.
// Ports:
//   clk_i, rst_i           clock; synchronous active-high reset
//   flush_i                drop all buffered entries and any same-cycle input
//   in_valid_i/in_ready_o  input handshake; in_ready_o depends only on state
//   instr_i, pc_i          raw instruction and its PC
//   out_valid_o/out_ready_i output handshake for the head entry
//   imm_o, imm_fmt_o       extended immediate and its format tag
//   pc_o, is_compressed_o, illegal_o   head entry side information
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned C_EXT  = 1,
   parameter int unsigned PIM_EN = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] imm_o,
   output logic [3:0]      imm_fmt_o,
   output logic [XLEN-1:0] pc_o,
   output logic            is_compressed_o,
   output logic            illegal_o
);

   logic [XLEN-1:0] w_dec_imm;
   logic [3:0]      w_dec_fmt;
   logic            w_dec_comp;
   logic            w_dec_ill;

   imm_decode_comb #(
      .XLEN   (XLEN),
      .C_EXT  (C_EXT),
      .PIM_EN (PIM_EN)
   ) u_dec (
      .instr_i      (instr_i),
      .imm_o        (w_dec_imm),
      .fmt_o        (w_dec_fmt),
      .compressed_o (w_dec_comp),
      .illegal_o    (w_dec_ill)
   );

   logic [XLEN-1:0] r_imm  [2];
   logic [XLEN-1:0] r_pc   [2];
   imm_entry_t      r_info [2];
   logic            r_rd_ptr;
   logic            r_wr_ptr;
   logic [1:0]      r_count;
   logic            w_push;
   logic            w_pop;

   assign in_ready_o  = (r_count != 2'd2);
   assign out_valid_o = (r_count != 2'd0);
   assign w_push      = in_valid_i & in_ready_o;
   assign w_pop       = out_valid_o & out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
         for (int k = 0; k < 2; k++) begin
            r_imm[k]  <= '0;
            r_pc[k]   <= '0;
            r_info[k] <= '{fmt: FMT_NONE, compressed: 1'b0, illegal: 1'b0};
         end
      end else if (flush_i) begin
         // Pointers realign so the next entry lands in slot 0; stale data is never visible.
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_imm[r_wr_ptr]  <= w_dec_imm;
            r_pc[r_wr_ptr]   <= pc_i;
            r_info[r_wr_ptr] <= '{fmt: imm_fmt_e'(w_dec_fmt), compressed: w_dec_comp,
                                  illegal: w_dec_ill};
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: ;
         endcase
      end
   end

   assign imm_o           = r_imm[r_rd_ptr];
   assign pc_o            = r_pc[r_rd_ptr];
   assign imm_fmt_o       = r_info[r_rd_ptr].fmt;
   assign is_compressed_o = r_info[r_rd_ptr].compressed;
   assign illegal_o       = r_info[r_rd_ptr].illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

   localparam int F_NONE = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5, F_SHAMT = 6;
   localparam int F_CI = 7, F_CIW = 8, F_CB = 12, F_CJ = 13;

   typedef struct {
      logic [31:0] imm;
      logic [3:0]  fmt;
      logic [31:0] pc;
      logic        comp;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, in_valid, out_ready, rdy_hi;
   logic [31:0] instr, pc;

   logic        in_ready_o, out_valid_o, is_compressed_o, illegal_o;
   logic [31:0] imm_o, pc_o;
   logic [3:0]  imm_fmt_o;

   logic        d1_in_ready, d1_out_valid, d1_comp, d1_ill;
   logic [63:0] d1_imm, d1_pc;
   logic [3:0]  d1_fmt;

   logic        d2_in_ready, d2_out_valid, d2_comp, d2_ill;
   logic [31:0] d2_imm, d2_pc;
   logic [3:0]  d2_fmt;

   imm_decode_stage #(.XLEN(32), .C_EXT(1), .PIM_EN(1)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
      .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid_o), .out_ready_i(out_ready),
      .imm_o(imm_o), .imm_fmt_o(imm_fmt_o), .pc_o(pc_o), .is_compressed_o(is_compressed_o),
      .illegal_o(illegal_o)
   );

   imm_decode_stage #(.XLEN(64), .C_EXT(1), .PIM_EN(1)) dut64 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(d1_in_ready), .instr_i(instr), .pc_i({32'h0, pc}),
      .out_valid_o(d1_out_valid), .out_ready_i(rdy_hi), .imm_o(d1_imm), .imm_fmt_o(d1_fmt),
      .pc_o(d1_pc), .is_compressed_o(d1_comp), .illegal_o(d1_ill)
   );

   imm_decode_stage #(.XLEN(32), .C_EXT(0), .PIM_EN(0)) dut_nc (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(d2_in_ready), .instr_i(instr), .pc_i(pc), .out_valid_o(d2_out_valid),
      .out_ready_i(rdy_hi), .imm_o(d2_imm), .imm_fmt_o(d2_fmt), .pc_o(d2_pc),
      .is_compressed_o(d2_comp), .illegal_o(d2_ill)
   );

   exp_t sb[$];
   exp_t cur;
   logic acc;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: record input acceptance, score any output transfer, then step past the edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (in_valid && in_ready_o && !flush && !rst) begin
         acc = 1'b1;
         sb.push_back(cur);
      end
      if (out_valid_o && out_ready && !flush && !rst) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL spurious_out observed=%h expected=none", imm_o);
         end else begin
            e = sb.pop_front();
            chk("out_imm", imm_o, e.imm);
            chk("out_fmt", imm_fmt_o, e.fmt);
            chk("out_pc", pc_o, e.pc);
            chk("out_comp", is_compressed_o, e.comp);
            chk("out_ill", illegal_o, e.ill);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] im,
                       input int fm, input logic cp, input logic il);
      instr    = ins;
      pc       = p;
      in_valid = 1'b1;
      cur      = '{im, 4'(fm), p, cp, il};
      acc      = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) tick();
      if (!acc) begin
         total++;
         bad++;
         $error("FAIL accept_timeout observed=%h expected=accepted", ins);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, out_valid_o, 1'b0);
      chk({tag, "_ready"}, in_ready_o, 1'b1);
      chk({tag, "_imm"}, imm_o, 32'h0);
      chk({tag, "_pc"}, pc_o, 32'h0);
      chk({tag, "_fmt"}, imm_fmt_o, 4'(F_NONE));
      chk({tag, "_comp"}, is_compressed_o, 1'b0);
      chk({tag, "_ill"}, illegal_o, 1'b0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rdy_hi = 1'b1;
      instr = '0; pc = '0; acc = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      chk_reset("por");

      // Decode patterns with the consumer always ready.
      send(32'hFFF00093, 32'h0000_0100, 32'hFFFF_FFFF, F_I, 1'b0, 1'b0);
      chk("latency_valid", out_valid_o, 1'b1);
      send(32'h01F09093, 32'h0000_0104, 32'h0000_001F, F_SHAMT, 1'b0, 1'b0);
      send(32'h03F09093, 32'h0000_0108, 32'h0000_001F, F_SHAMT, 1'b0, 1'b0);
      chk("x64_shamt", d1_imm, 64'h3F);
      chk("x64_shamt_fmt", d1_fmt, 4'(F_SHAMT));
      send(32'hFE000EE3, 32'h0000_010C, 32'hFFFF_FFFC, F_B, 1'b0, 1'b0);
      send(32'h123450B7, 32'h0000_0110, 32'h1234_5000, F_U, 1'b0, 1'b0);
      send(32'h800000B7, 32'h0000_0114, 32'h8000_0000, F_U, 1'b0, 1'b0);
      chk("x64_lui_sext", d1_imm, 64'hFFFF_FFFF_8000_0000);
      send(32'h00112423, 32'h0000_0118, 32'h0000_0008, F_S, 1'b0, 1'b0);
      send(32'h0080006F, 32'h0000_011C, 32'h0000_0008, F_J, 1'b0, 1'b0);
      send(32'h0000040B, 32'h0000_0120, 32'h0000_0008, F_S, 1'b0, 1'b0);
      chk("nopim_ill", d2_ill, 1'b1);
      chk("nopim_fmt", d2_fmt, 4'(F_NONE));
      send(32'h000050FD, 32'h0000_0124, 32'hFFFF_FFFF, F_CI, 1'b1, 1'b0);
      chk("noc_ill", d2_ill, 1'b1);
      chk("noc_imm", d2_imm, 32'h0);
      chk("noc_comp", d2_comp, 1'b0);
      send(32'h0000BFFD, 32'h0000_0126, 32'hFFFF_FFFE, F_CJ, 1'b1, 1'b0);
      send(32'hABCD0040, 32'h0000_0128, 32'h0000_0004, F_CIW, 1'b1, 1'b0);
      send(32'h0000DC7D, 32'h0000_012A, 32'hFFFF_FFFE, F_CB, 1'b1, 1'b0);
      send(32'h0000007F, 32'h0000_012C, 32'h0000_0000, F_NONE, 1'b0, 1'b1);
      drain();
      chk("idle_valid", out_valid_o, 1'b0);

      // Backpressure: two entries fill the buffer, a third waits, order is preserved.
      out_ready = 1'b0;
      send(32'h00500093, 32'h0000_0200, 32'h5, F_I, 1'b0, 1'b0);
      send(32'h00700093, 32'h0000_0204, 32'h7, F_I, 1'b0, 1'b0);
      chk("full_ready", in_ready_o, 1'b0);
      instr = 32'h00900093; pc = 32'h0000_0208; in_valid = 1'b1;
      cur = '{32'h9, 4'(F_I), 32'h0000_0208, 1'b0, 1'b0};
      acc = 1'b0;
      repeat (3) begin
         tick();
         chk("hold_imm", imm_o, 32'h5);
         chk("hold_valid", out_valid_o, 1'b1);
      end
      chk("c_held_off", acc, 1'b0);
      out_ready = 1'b1;
      send(32'h00900093, 32'h0000_0208, 32'h9, F_I, 1'b0, 1'b0);
      drain();

      // Flush with a full buffer and a pending input.
      out_ready = 1'b0;
      send(32'h00500093, 32'h0000_0300, 32'h5, F_I, 1'b0, 1'b0);
      send(32'h00700093, 32'h0000_0304, 32'h7, F_I, 1'b0, 1'b0);
      instr = 32'h00D00093; pc = 32'h0000_0308; in_valid = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      sb.delete();
      chk("flush2_valid", out_valid_o, 1'b0);
      chk("flush2_ready", in_ready_o, 1'b1);

      // Flush with one entry while the input is acceptable: that input is dropped too.
      send(32'h00500093, 32'h0000_0310, 32'h5, F_I, 1'b0, 1'b0);
      instr = 32'h00D00093; pc = 32'h0000_0314; in_valid = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      sb.delete();
      chk("flush1_valid", out_valid_o, 1'b0);
      out_ready = 1'b1;
      tick();
      chk("flush_stays_empty", out_valid_o, 1'b0);
      send(32'h00B00093, 32'h0000_0318, 32'hB, F_I, 1'b0, 1'b0);
      drain();

      // Reset in the middle of a burst.
      out_ready = 1'b0;
      send(32'h00500093, 32'h0000_0400, 32'h5, F_I, 1'b0, 1'b0);
      send(32'h00700093, 32'h0000_0404, 32'h7, F_I, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      chk_reset("midrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
